// File: rtl/scan_result_writer_if.sv
// Result-beat input and output-buffer write port of the scan writer.
// slave: writer side; master: source of beats and owner of the buffer.
interface scan_result_writer_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_ready;
  logic          mem_we;
  logic [11:0]   mem_addr;
  logic [DW-1:0] mem_wdata;

  modport slave (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/scan_result_writer.sv
// Writes tiled/strided scan results to raster addresses of a 64x64 buffer.
// Ports: clk, rst, start, num, bus (beats in / buffer write out),
// busy, blk_idx, blk_change, done, cfg_err.
module scan_result_writer #(
  parameter int DW  = 16,
  parameter int IMG = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [6:0]           num,
  scan_result_writer_if.slave  bus,
  output logic                 busy,
  output logic [6:0]           blk_idx,
  output logic                 blk_change,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LMAX = 6'(IMG - 1);

  state_t        state_q, state_d;
  logic [5:0]    c_q, c_d;
  logic [2:0]    ii_q, ii_d;
  logic [2:0]    jj_q, jj_d;
  logic [6:0]    nb_q, nb_d;
  logic [6:0]    num_q, num_d;
  logic          we_q, we_d;
  logic [11:0]   addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          bc_q, bc_d;
  logic          done_q, done_d;
  logic          cerr_q, cerr_d;

  logic       acc;
  logic       num_ok;
  logic       c_last;
  logic       last;
  logic [5:0] lane;

  assign acc    = bus.in_valid && bus.in_ready;
  assign num_ok = (num != 7'd0) &&
                  ((num & (num - 7'd1)) == 7'd0);

  // lane = c + nb*num; never exceeds 63 while running
  assign lane   = c_q + 6'(nb_q * num_q);
  assign c_last = ({1'b0, c_q} == num_q - 7'd1);
  assign last   = c_last && (ii_q == 3'd7) &&
                  (jj_q == 3'd7) && (lane == LMAX);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    ii_d    = ii_q;
    jj_d    = jj_q;
    nb_d    = nb_q;
    num_d   = num_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bc_d    = 1'b0;
    done_d  = 1'b0;
    cerr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_ok) begin
            num_d   = num;
            c_d     = '0;
            ii_d    = '0;
            jj_d    = '0;
            nb_d    = '0;
            state_d = RUN;
          end else begin
            cerr_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (acc) begin
          we_d    = 1'b1;
          // {j, i} with j = 8*lane[5:3]+jj, i = 8*lane[2:0]+ii
          addr_d  = {lane[5:3], jj_q, lane[2:0], ii_q};
          wdata_d = bus.in_data;
          if (!c_last) begin
            c_d = c_q + 6'd1;
          end else begin
            c_d = '0;
            if (ii_q != 3'd7) begin
              ii_d = ii_q + 3'd1;
            end else begin
              ii_d = '0;
              if (jj_q != 3'd7) begin
                jj_d = jj_q + 3'd1;
              end else begin
                jj_d = '0;
                nb_d = nb_q + 7'd1;
                bc_d = 1'b1;
              end
            end
          end
          if (last) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      ii_q    <= '0;
      jj_q    <= '0;
      nb_q    <= '0;
      num_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bc_q    <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      ii_q    <= ii_d;
      jj_q    <= jj_d;
      nb_q    <= nb_d;
      num_q   <= num_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bc_q    <= bc_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
    end
  end

  assign bus.in_ready  = (state_q == RUN) && bus.mem_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != IDLE);
  assign blk_idx       = nb_q;
  assign blk_change    = bc_q;
  assign done          = done_q;
  assign cfg_err       = cerr_q;

endmodule

// File: doc/scan_result_writer.md
Name: scan_result_writer

Overview:
- Write-back end of the tiled 64x64 feature-map scan used by the convolution datapath.
- Accepts one result per handshake, in the same tiled, strided order the read-side address counter uses to issue pixels.
- Regenerates that traversal internally and writes each result to its raster address in the 64x64 output buffer.
- Reports block progress and a completion pulse.

Parameters:
- DW, 16, result data width (bits).
- IMG, 64, image side in pixels; fixed to 64, other values unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a frame; sampled only in IDLE.
- num  in  7  results per coarse group (parallel lanes); latched on accepted start.
- in_valid  in  1  result beat valid.
- in_data  in  DW  result beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- mem_ready  in  1  output buffer can take a write this cycle.
- mem_we  out  1  buffer write enable.
- mem_addr  out  12  buffer address {j[5:0], i[5:0]}.
- mem_wdata  out  DW  buffer write data.
- busy  out  1  state != IDLE.
- blk_idx  out  7  current block number nb.
- blk_change  out  1  one-cycle pulse when a block completes.
- done  out  1  one-cycle pulse on final write.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE; c, ii, jj, nb, num_q = 0.
  - mem_we, mem_addr, mem_wdata, blk_change, done, cfg_err = 0; blk_idx=0; in_ready=0.
  - No write is issued for a beat accepted in the reset cycle.
- States: IDLE, RUN, DONE.
- IDLE -> start:
  - num in {1,2,4,8,16,32,64}: num_q<=num, counters cleared, -> RUN.
  - Otherwise: cfg_err=1 for one cycle, stay IDLE.
  - start outside IDLE is ignored; num changes after latch are ignored.
- in_ready = (state==RUN) && mem_ready (combinational). in_ready is 0 in IDLE and DONE.
- Accepted beat, using current counters before they advance:
  - L = c + nb*num_q, 7-bit, always <= 63.
  - i = 8*L[2:0] + ii.
  - j = 8*(L>>3) + jj.
- Registered write, latency 1: the cycle after accept, mem_we=1, mem_addr={j,i}, mem_wdata=in_data. mem_we=0 on cycles with no accept.
- Counter advance on each accept:
  - if c < num_q-1: c++.
  - else c=0, then: if ii<7: ii++; else ii=0, then: if jj<7: jj++; else jj=0, nb++, blk_change=1 next cycle.
- Last beat: nb==64/num_q-1, jj==7, ii==7, c==num_q-1. 4096 beats per frame; each address written exactly once.
- Last beat accepted -> DONE. Final mem_we and done=1 occur in the same cycle. DONE -> IDLE next cycle.
- Counters do not wrap; in_valid in DONE/IDLE is held off by in_ready=0.
- blk_idx is registered nb. On the final block, blk_change pulses together with done, and blk_idx returns to 0 on the next frame's start.
- Stall: mem_ready=0 deasserts in_ready the same cycle. No beat is lost or duplicated, and the address sequence is unaffected.

Test Plan:
- num=1, continuous valid -> beat0 addr 0, beat1 addr 1, beat8 addr 64, beat64 addr 8 with blk_change pulse; blk_idx=1 after beat 63.
- num=4 -> beats 0..4 write addrs 0, 8, 16, 24, 1; 16 blocks total; done after write 4096 and busy low one cycle later.
- num=64 full frame with random in_valid and mem_ready gaps -> exactly 4096 writes, all addresses 0..4095 hit once, data matches beat order, no write while mem_ready was low at accept.
- start with num=3, then num=0 -> cfg_err pulses each time, busy stays 0, no writes; start with num=8 while busy -> ignored.
- rst asserted at beat 1000 of a num=2 frame -> all outputs 0 immediately; a new start num=2 restarts at addr 0.
- num=16 final beat -> mem_we, done, blk_change all high in the same cycle; in_valid held high afterwards -> in_ready=0, no extra writes.
